car_state_ctrl: RTL and testbench
=================================

// Module: car_state_ctrl
// PURPOSE
//  Engine/drive FSM of the car simulator. Turns debounced driver controls into the 2-bit car
//  state consumed by the mileage/display stage (its `state` input) and emits a mileage tick.
//  One state register, one shared hold/idle counter, one tick prescaler, one gear-edge detector.
// PARAMETERS
//  PWR_ON_HOLD_CYC   100_000_000  cycles power_on_btn must stay high to leave OFF (1 s @100 MHz)
//  IDLE_TIMEOUT_CYC  500_000_000  cycles without throttle in NOT_STARTING before auto power-off
//  TICK_CYC          10_000_000   cycles between mile_tick pulses while MOVING
// PORTS
//  clk            in   1  system clock; all logic on posedge
//  rst            in   1  asynchronous, active-high reset
//  power_on_btn   in   1  power-on button, debounced, level
//  power_off_btn  in   1  power-off button, debounced, level
//  throttle       in   1  throttle switch, level
//  clutch         in   1  clutch switch, level
//  brake          in   1  brake switch, level
//  reverse_sw     in   1  gear switch (1 = reverse), level
//  state          out  2  OFF=2'b00 NOT_STARTING=2'b01 STARTING=2'b11 MOVING=2'b10, registered
//  reverse        out  1  registered copy of reverse_sw, held 0 while state==OFF
//  mile_tick      out  1  one-cycle pulse, only while state==MOVING
// BEHAVIOUR
//  Reset (async, rst=1): state=OFF, reverse=0, mile_tick=0; all counters and gear register 0.
//  All transitions take effect on the clk edge where the condition is sampled (1-cycle latency).
//  Priority, every non-OFF state: power_off_btn=1 -> OFF (overrides all other inputs).
//  gear_chg = reverse_sw != registered reverse_sw. gear_chg with clutch=0 in STARTING or MOVING
//   -> OFF (second priority). With clutch=1 the gear change is accepted, no state change.
//  OFF: counter increments while power_on_btn=1, clears when 0 or power_off_btn=1;
//   counter reaching PWR_ON_HOLD_CYC-1 with button still high -> NOT_STARTING, counter cleared.
//  NOT_STARTING: throttle&clutch&!brake -> STARTING; throttle&!clutch -> OFF (stall);
//   else stay. Idle counter counts cycles with throttle=0, clears on throttle=1 or state exit;
//   reaching IDLE_TIMEOUT_CYC-1 -> OFF.
//  STARTING: throttle&!clutch&!brake -> MOVING; else stay.
//  MOVING: brake -> NOT_STARTING; else (!throttle | clutch) -> STARTING; else stay.
//  Entry into NOT_STARTING from any state clears the idle counter.
//  mile_tick: prescaler counts 0..TICK_CYC-1 only in MOVING, pulses on wrap (every TICK_CYC
//   cycles of continuous MOVING); prescaler cleared on leaving MOVING, no partial carry-over.
//  Counters sized $clog2(max param); never wrap outside defined compare points.
//  power_on_btn while already powered: ignored. Both buttons high in OFF: stay OFF, counter clear.
//  rst asserted mid-hold or mid-MOVING: immediate return to reset values, no tick emitted.
// TESTING  (PWR_ON_HOLD_CYC=4, IDLE_TIMEOUT_CYC=8, TICK_CYC=3)
//  Power-on: power_on_btn high 4 cycles -> state 00->01; high 3 cycles then low -> stays 00.
//  Start/drive: in 01, clutch=1,throttle=1 -> 11; then clutch=0 -> 10; mile_tick every 3rd cycle.
//  Stall/brake: in 01 throttle=1,clutch=0 -> 00; in 10 brake=1 -> 01; in 10 throttle=0 -> 11.
//  Gear: in 10 toggle reverse_sw with clutch=0 -> 00, reverse=0; with clutch=1 -> reverse=1, stay.
//  Idle: in 01 hold throttle=0 for 8 cycles -> 00; throttle pulse at cycle 5 restarts count.
//  Priority/reset: in 10 power_off_btn=1 with throttle=1 -> 00; rst mid-MOVING -> 00, tick 0.

Source files
------------

// File: rtl/car_state_ctrl_if.sv
// Driver-control / car-state bundle between the control inputs and car_state_ctrl.
//  master: drives the debounced driver controls, observes state/reverse/mile_tick
//  slave : car_state_ctrl side
interface car_state_ctrl_if;
  logic       power_on_btn;
  logic       power_off_btn;
  logic       throttle;
  logic       clutch;
  logic       brake;
  logic       reverse_sw;
  logic [1:0] state;
  logic       reverse;
  logic       mile_tick;

  modport master (
    output power_on_btn, power_off_btn, throttle, clutch, brake, reverse_sw,
    input  state, reverse, mile_tick
  );

  modport slave (
    input  power_on_btn, power_off_btn, throttle, clutch, brake, reverse_sw,
    output state, reverse, mile_tick
  );
endinterface

// File: rtl/car_state_ctrl.sv
// Engine/drive FSM of the car simulator.
// Turns debounced driver controls into the 2-bit car state for the mileage/display
// stage and emits a one-cycle mile tick every TICK_CYC cycles of continuous MOVING.
// Ports:
//  clk  - system clock, posedge
//  rst  - asynchronous active-high reset
//  bus  - slave side of car_state_ctrl_if: driver controls in; state, reverse, mile_tick out
module car_state_ctrl #(
  parameter int unsigned PWR_ON_HOLD_CYC  = 100_000_000,
  parameter int unsigned IDLE_TIMEOUT_CYC = 500_000_000,
  parameter int unsigned TICK_CYC         = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  car_state_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_OFF          = 2'b00;
  localparam logic [1:0] ST_NOT_STARTING = 2'b01;
  localparam logic [1:0] ST_STARTING     = 2'b11;
  localparam logic [1:0] ST_MOVING       = 2'b10;

  // One counter is shared by the OFF hold timer and the NOT_STARTING idle timer.
  localparam int unsigned CNT_MAX = (PWR_ON_HOLD_CYC > IDLE_TIMEOUT_CYC) ?
                                    PWR_ON_HOLD_CYC : IDLE_TIMEOUT_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned PRE_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             tick_q, tick_d;
  logic             gear_q, gear_d;
  logic             reverse_q, reverse_d;
  logic             gear_chg;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      gear_q    <= 1'b0;
      reverse_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      gear_q    <= gear_d;
      reverse_q <= reverse_d;
    end
  end

  // Next-state, counters and registered-output values
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    presc_d   = '0;
    tick_d    = 1'b0;
    gear_d    = bus.reverse_sw;
    gear_chg  = (bus.reverse_sw != gear_q);

    case (state_q)
      ST_OFF: begin
        // Hold timer runs only while power-on alone is pressed.
        if (bus.power_on_btn && !bus.power_off_btn) begin
          if (cnt_q == CNT_W'(PWR_ON_HOLD_CYC - 1)) begin
            state_d = ST_NOT_STARTING;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_NOT_STARTING: begin
        if (bus.power_off_btn) begin
          state_d = ST_OFF;
        end else if (bus.throttle && bus.clutch && !bus.brake) begin
          state_d = ST_STARTING;
        end else if (bus.throttle && !bus.clutch) begin
          state_d = ST_OFF;
        end else if (!bus.throttle) begin
          // Idle timer; any throttle press leaves cnt_d at its cleared default.
          if (cnt_q == CNT_W'(IDLE_TIMEOUT_CYC - 1)) begin
            state_d = ST_OFF;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_STARTING: begin
        if (bus.power_off_btn) begin
          state_d = ST_OFF;
        end else if (gear_chg && !bus.clutch) begin
          state_d = ST_OFF;
        end else if (bus.throttle && !bus.clutch && !bus.brake) begin
          state_d = ST_MOVING;
        end
      end
      ST_MOVING: begin
        if (bus.power_off_btn) begin
          state_d = ST_OFF;
        end else if (gear_chg && !bus.clutch) begin
          state_d = ST_OFF;
        end else if (bus.brake) begin
          state_d = ST_NOT_STARTING;
        end else if (!bus.throttle || bus.clutch) begin
          state_d = ST_STARTING;
        end
      end
      default: state_d = ST_OFF;
    endcase

    // Prescaler only advances while staying in MOVING, so a tick never lands outside it.
    if (state_q == ST_MOVING && state_d == ST_MOVING) begin
      if (presc_q == PRE_W'(TICK_CYC - 1)) begin
        tick_d = 1'b1;
      end else begin
        presc_d = presc_q + PRE_W'(1);
      end
    end

    reverse_d = (state_d == ST_OFF) ? 1'b0 : bus.reverse_sw;
  end

  assign bus.state     = state_q;
  assign bus.reverse   = reverse_q;
  assign bus.mile_tick = tick_q;

endmodule

// File: tb/tb_car_state_ctrl.sv
// Directed bench for car_state_ctrl with small timing parameters
// (hold 4, idle timeout 8, tick period 3).
module tb_car_state_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  car_state_ctrl_if bus ();

  car_state_ctrl #(
    .PWR_ON_HOLD_CYC (4),
    .IDLE_TIMEOUT_CYC(8),
    .TICK_CYC        (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.power_on_btn  = 1'b0;
    bus.power_off_btn = 1'b0;
    bus.throttle      = 1'b0;
    bus.clutch        = 1'b0;
    bus.brake         = 1'b0;
    bus.reverse_sw    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Leaves the DUT just after entering NOT_STARTING, all controls released.
  task automatic power_up();
    bus.power_on_btn = 1'b1;
    repeat (4) tick();
    bus.power_on_btn = 1'b0;
  endtask

  // From NOT_STARTING: STARTING, then MOVING (entry edge just passed).
  task automatic goto_moving();
    bus.throttle = 1'b1;
    bus.clutch   = 1'b1;
    tick();
    bus.clutch   = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.power_on_btn = 1'b1;
    bus.throttle     = 1'b1;
    bus.reverse_sw   = 1'b1;
    rst = 1'b1;
    tick();
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", bus.state); end
    total++; if (bus.reverse !== 1'b0) begin bad++; $display("FAIL reset_reverse got=%b exp=0", bus.reverse); end
    total++; if (bus.mile_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", bus.mile_tick); end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_power_on();
    do_reset();
    bus.power_on_btn = 1'b1;
    repeat (3) tick();
    bus.power_on_btn = 1'b0;
    tick();
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL pwr_short got=%b exp=00", bus.state); end
    bus.power_on_btn  = 1'b1;
    bus.power_off_btn = 1'b1;
    repeat (6) tick();
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL pwr_both_btn got=%b exp=00", bus.state); end
    bus.power_off_btn = 1'b0;
    repeat (3) tick();
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL pwr_hold3 got=%b exp=00", bus.state); end
    tick();
    total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL pwr_hold4 got=%b exp=01", bus.state); end
    // Button still held while powered: ignored.
    repeat (3) tick();
    total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL pwr_ignored got=%b exp=01", bus.state); end
    bus.power_on_btn = 1'b0;
  endtask

  task automatic test_drive();
    logic exp_tick;
    do_reset();
    power_up();
    bus.throttle = 1'b1;
    bus.clutch   = 1'b1;
    tick();
    total++; if (bus.state !== 2'b11) begin bad++; $display("FAIL drive_starting got=%b exp=11", bus.state); end
    bus.clutch = 1'b0;
    tick();
    total++; if (bus.state !== 2'b10) begin bad++; $display("FAIL drive_moving got=%b exp=10", bus.state); end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_tick = (i % 3 == 2);
      total++; if (bus.mile_tick !== exp_tick) begin bad++; $display("FAIL drive_tick[%0d] got=%b exp=%b", i, bus.mile_tick, exp_tick); end
    end
    total++; if (bus.state !== 2'b10) begin bad++; $display("FAIL drive_still_moving got=%b exp=10", bus.state); end
  endtask

  task automatic test_back_to_back();
    logic exp_tick;
    do_reset();
    power_up();
    goto_moving();
    repeat (2) tick();
    // Leave MOVING just before the wrap; the partial count must be dropped.
    bus.throttle = 1'b0;
    tick();
    total++; if (bus.mile_tick !== 1'b0) begin bad++; $display("FAIL b2b_no_tick_on_exit got=%b exp=0", bus.mile_tick); end
    bus.throttle = 1'b1;
    tick();
    total++; if (bus.state !== 2'b10) begin bad++; $display("FAIL b2b_reenter got=%b exp=10", bus.state); end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_tick = (i == 2);
      total++; if (bus.mile_tick !== exp_tick) begin bad++; $display("FAIL b2b_tick[%0d] got=%b exp=%b", i, bus.mile_tick, exp_tick); end
    end
  endtask

  task automatic test_stall_brake();
    do_reset();
    power_up();
    bus.throttle = 1'b1;
    tick();
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL stall got=%b exp=00", bus.state); end
    bus.throttle = 1'b0;
    power_up();
    goto_moving();
    bus.brake = 1'b1;
    tick();
    total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL brake got=%b exp=01", bus.state); end
    bus.brake    = 1'b0;
    bus.throttle = 1'b0;
    tick();
    goto_moving();
    bus.throttle = 1'b0;
    tick();
    total++; if (bus.state !== 2'b11) begin bad++; $display("FAIL release_throttle got=%b exp=11", bus.state); end
  endtask

  task automatic test_gear();
    do_reset();
    power_up();
    goto_moving();
    bus.reverse_sw = 1'b1;
    tick();
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL gear_no_clutch_state got=%b exp=00", bus.state); end
    total++; if (bus.reverse !== 1'b0) begin bad++; $display("FAIL gear_no_clutch_rev got=%b exp=0", bus.reverse); end
    bus.reverse_sw = 1'b0;
    bus.throttle   = 1'b0;
    tick();
    power_up();
    goto_moving();
    bus.clutch     = 1'b1;
    bus.reverse_sw = 1'b1;
    tick();
    total++; if (bus.state !== 2'b11) begin bad++; $display("FAIL gear_clutch_state got=%b exp=11", bus.state); end
    total++; if (bus.reverse !== 1'b1) begin bad++; $display("FAIL gear_clutch_rev got=%b exp=1", bus.reverse); end
    bus.throttle   = 1'b0;
    bus.reverse_sw = 1'b0;
    tick();
    total++; if (bus.state !== 2'b11) begin bad++; $display("FAIL gear_starting_state got=%b exp=11", bus.state); end
    total++; if (bus.reverse !== 1'b0) begin bad++; $display("FAIL gear_starting_rev got=%b exp=0", bus.reverse); end
  endtask

  task automatic test_idle();
    do_reset();
    power_up();
    repeat (7) tick();
    total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL idle_7 got=%b exp=01", bus.state); end
    tick();
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL idle_8 got=%b exp=00", bus.state); end
    power_up();
    repeat (4) tick();
    // Throttle pulse that causes no transition but restarts the idle count.
    bus.throttle = 1'b1;
    bus.clutch   = 1'b1;
    bus.brake    = 1'b1;
    tick();
    bus.throttle = 1'b0;
    bus.clutch   = 1'b0;
    bus.brake    = 1'b0;
    repeat (7) tick();
    total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL idle_restart_7 got=%b exp=01", bus.state); end
    tick();
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL idle_restart_8 got=%b exp=00", bus.state); end
  endtask

  task automatic test_priority_reset();
    do_reset();
    power_up();
    goto_moving();
    bus.power_off_btn = 1'b1;
    tick();
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL power_off got=%b exp=00", bus.state); end
    clear_inputs();
    tick();
    power_up();
    goto_moving();
    repeat (2) tick();
    rst = 1'b1;
    #1;
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL rst_moving_state got=%b exp=00", bus.state); end
    tick();
    total++; if (bus.mile_tick !== 1'b0) begin bad++; $display("FAIL rst_moving_tick got=%b exp=0", bus.mile_tick); end
    rst = 1'b0;
    clear_inputs();
    // Reset mid-hold restarts the hold count.
    bus.power_on_btn = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    repeat (3) tick();
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL rst_hold_3 got=%b exp=00", bus.state); end
    tick();
    total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL rst_hold_4 got=%b exp=01", bus.state); end
    bus.power_on_btn = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_inputs();
    test_reset();
    test_power_on();
    test_drive();
    test_back_to_back();
    test_stall_brake();
    test_gear();
    test_idle();
    test_priority_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
